// File: rtl/pc_fetch_pkg.sv
// pc_fetch_pkg: shared constants and types for the fetch stage.
//   PC_BUS                    default PC / instruction-memory address width
//   INST_BUS                  default instruction word width
//   PC_JUMP / PC_JUMP_DISABLE encodings of the jump-mux select
//   RESET_PC_DEF              default fetch address after reset
//   fetch_state_e             request-tracking FSM states
package pc_fetch_pkg;

  localparam int PC_BUS   = 16;
  localparam int INST_BUS = 16;

  localparam logic PC_JUMP         = 1'b1;
  localparam logic PC_JUMP_DISABLE = 1'b0;

  localparam logic [PC_BUS-1:0] RESET_PC_DEF = '0;

  typedef enum logic [1:0] {
    FETCH_IDLE    = 2'd0,
    FETCH_WAIT    = 2'd1,
    FETCH_DISCARD = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/pc_fetch_if.sv
// pc_fetch_if: instruction-memory fetch handshake.
//   imem_req   fetch request (from fetch stage)
//   imem_addr  word address, stable while imem_req is high
//   imem_ack   fetch complete, imem_data valid this cycle
//   imem_data  fetched instruction word
// master = fetch stage, slave = instruction memory.
interface pc_fetch_if
  import pc_fetch_pkg::*;
#(
  parameter int PC_WIDTH   = PC_BUS,
  parameter int INST_WIDTH = INST_BUS
);

  logic                  imem_req;
  logic [PC_WIDTH-1:0]   imem_addr;
  logic                  imem_ack;
  logic [INST_WIDTH-1:0] imem_data;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_data
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_data
  );

endinterface

// File: rtl/pc_fetch_buf.sv
// fetch_buf: 2-entry synchronous FIFO for fetched {pc, instruction} pairs.
//   clk, rst_n  clock, asynchronous active-low reset
//   i_push      write i_data at the tail
//   i_pop       drop the head (ignored when empty)
//   i_flush     empty the FIFO; overrides push and pop
//   i_data      entry to write
//   o_count     number of valid entries (0..2)
//   o_valid     head entry valid
//   o_head      head entry
module fetch_buf #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic         i_flush,
  input  logic [W-1:0] i_data,
  output logic [1:0]   o_count,
  output logic         o_valid,
  output logic [W-1:0] o_head
);

  logic [W-1:0] r_mem [2];
  logic         r_rd;
  logic         r_wr;
  logic [1:0]   r_count;

  logic         w_push;
  logic         w_pop;

  // Guards keep the pointers consistent even if a caller misbehaves.
  assign w_push = i_push && (r_count != 2'd2);
  assign w_pop  = i_pop  && (r_count != 2'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_rd     <= 1'b0;
      r_wr     <= 1'b0;
      r_count  <= 2'd0;
    end else if (i_flush) begin
      r_rd    <= 1'b0;
      r_wr    <= 1'b0;
      r_count <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wr] <= i_data;
        r_wr        <= ~r_wr;
      end
      if (w_pop) begin
        r_rd <= ~r_rd;
      end
      r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

  assign o_count = r_count;
  assign o_valid = (r_count != 2'd0);
  assign o_head  = r_mem[r_rd];

endmodule

// File: rtl/pc_fetch.sv
// pc_fetch: fetch stage around the PC jump mux.
//   clk, rst_n   clock, asynchronous active-low reset
//   PC_plus      PC + 1 (word addressed) to the jump mux
//   PC_new       next PC chosen by the jump mux
//   pc_jump_op   PC_JUMP when a jump is taken this cycle (PC_new = target)
//   imem         instruction-memory req/ack bus (master side)
//   if_valid     fetch buffer head valid
//   if_pc        PC of the head instruction
//   if_inst      head instruction word
//   id_ready     decode consumes the head when if_valid is high
module pc_fetch
  import pc_fetch_pkg::*;
#(
  parameter int                  PC_WIDTH   = PC_BUS,
  parameter int                  INST_WIDTH = INST_BUS,
  parameter logic [PC_WIDTH-1:0] RESET_PC   = RESET_PC_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic [PC_WIDTH-1:0]   PC_plus,
  input  logic [PC_WIDTH-1:0]   PC_new,
  input  logic                  pc_jump_op,
  pc_fetch_if.master            imem,
  output logic                  if_valid,
  output logic [PC_WIDTH-1:0]   if_pc,
  output logic [INST_WIDTH-1:0] if_inst,
  input  logic                  id_ready
);

  localparam int EW = PC_WIDTH + INST_WIDTH;

  fetch_state_e          r_state;
  logic [PC_WIDTH-1:0]   r_pc;
  logic [PC_WIDTH-1:0]   r_addr;
  logic                  r_req;

  logic                  w_jump;
  logic                  w_ack;
  logic                  w_push;
  logic                  w_pop;
  logic [1:0]            w_count;
  logic [EW-1:0]         w_head;

  assign w_jump = (pc_jump_op == PC_JUMP);
  assign w_ack  = imem.imem_ack;
  // Data returning in WAIT is kept unless a jump in the same cycle kills it.
  assign w_push = (r_state == FETCH_WAIT) && w_ack && !w_jump;
  assign w_pop  = if_valid && id_ready;

  assign PC_plus = r_pc + PC_WIDTH'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= FETCH_IDLE;
      r_pc    <= RESET_PC;
      r_addr  <= RESET_PC;
      r_req   <= 1'b0;
    end else begin
      case (r_state)
        FETCH_IDLE: begin
          // Acks arriving here belong to nothing and are ignored.
          if (w_jump) begin
            r_pc <= PC_new;
          end else if (w_count < 2'd2) begin
            r_addr  <= r_pc;
            r_state <= FETCH_WAIT;
            r_req   <= 1'b1;
          end
        end
        FETCH_WAIT: begin
          // Without a jump PC_new equals PC_plus, so one load covers both cases.
          if (w_ack) begin
            r_pc    <= PC_new;
            r_state <= FETCH_IDLE;
            r_req   <= 1'b0;
          end else if (w_jump) begin
            r_pc    <= PC_new;
            r_state <= FETCH_DISCARD;
          end
        end
        FETCH_DISCARD: begin
          // The stale request must still complete before a new one may issue.
          if (w_jump) begin
            r_pc <= PC_new;
          end
          if (w_ack) begin
            r_state <= FETCH_IDLE;
            r_req   <= 1'b0;
          end
        end
        default: begin
          r_state <= FETCH_IDLE;
          r_req   <= 1'b0;
        end
      endcase
    end
  end

  assign imem.imem_req  = r_req;
  assign imem.imem_addr = r_addr;

  fetch_buf #(.W(EW)) u_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (w_jump),
    .i_data  ({r_addr, imem.imem_data}),
    .o_count (w_count),
    .o_valid (if_valid),
    .o_head  (w_head)
  );

  assign if_pc   = w_head[EW-1:INST_WIDTH];
  assign if_inst = w_head[INST_WIDTH-1:0];

endmodule

// File: tb/tb_pc_fetch.sv
// tb_pc_fetch: directed bench for pc_fetch. Memory model returns
// addr + 0x1000 after a programmable number of wait cycles; the jump mux
// is modelled as PC_new = jump ? target : PC_plus.
module tb_pc_fetch;
  import pc_fetch_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [15:0] PC_plus;
  logic [15:0] PC_new;
  logic        jump;
  logic [15:0] tgt;
  logic        if_valid;
  logic [15:0] if_pc;
  logic [15:0] if_inst;
  logic        id_ready;

  int          mdly;
  int          cnt;
  int          n_cmp;
  int          n_bad;

  logic [15:0] q_pc[$];
  logic [15:0] q_inst[$];

  pc_fetch_if #(.PC_WIDTH(16), .INST_WIDTH(16)) bus ();

  pc_fetch #(.PC_WIDTH(16), .INST_WIDTH(16), .RESET_PC(16'h0000)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .PC_plus    (PC_plus),
    .PC_new     (PC_new),
    .pc_jump_op (jump),
    .imem       (bus),
    .if_valid   (if_valid),
    .if_pc      (if_pc),
    .if_inst    (if_inst),
    .id_ready   (id_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb PC_new = jump ? tgt : PC_plus;

  // Instruction memory: ack after mdly waiting cycles of an outstanding request.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt <= 0;
    else if (bus.imem_req && !bus.imem_ack) cnt <= cnt + 1;
    else cnt <= 0;
  end
  assign bus.imem_ack  = bus.imem_req && (cnt >= mdly);
  assign bus.imem_data = bus.imem_addr + 16'h1000;

  // Record every entry decode actually consumes.
  always @(negedge clk) begin
    if (rst_n && if_valid && id_ready && !jump) begin
      q_pc.push_back(if_pc);
      q_inst.push_back(if_inst);
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_q();
    q_pc.delete();
    q_inst.delete();
  endtask

  task automatic wait_pops(input int n, input string tag);
    for (int i = 0; i < 80 && q_pc.size() < n; i++) tick();
    check_eq({tag, "_npops"}, 32'(q_pc.size() >= n), 32'd1);
  endtask

  task automatic wait_req(input logic val, input string tag);
    for (int i = 0; i < 40 && bus.imem_req !== val; i++) tick();
    check_eq({tag, "_req"}, 32'(bus.imem_req), 32'(val));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] old_addr;
    logic        found;
    n_cmp    = 0;
    n_bad    = 0;
    rst_n    = 1'b0;
    jump     = PC_JUMP_DISABLE;
    tgt      = 16'h0000;
    id_ready = 1'b1;
    mdly     = 0;

    // Reset state
    tick();
    tick();
    check_eq("rst_req",   32'(bus.imem_req),  32'd0);
    check_eq("rst_addr",  32'(bus.imem_addr), 32'h0);
    check_eq("rst_valid", 32'(if_valid),      32'd0);
    check_eq("rst_pc",    32'(if_pc),         32'h0);
    check_eq("rst_inst",  32'(if_inst),       32'h0);
    check_eq("rst_plus",  32'(PC_plus),       32'h1);

    // Zero-wait streaming from RESET_PC
    rst_n = 1'b1;
    tick();
    check_eq("t1_req_first",  32'(bus.imem_req),  32'd1);
    check_eq("t1_addr_first", 32'(bus.imem_addr), 32'h0);
    tick();
    check_eq("t1_req_low",  32'(bus.imem_req), 32'd0);
    check_eq("t1_plus",     32'(PC_plus),      32'h2);
    check_eq("t1_valid",    32'(if_valid),     32'd1);
    check_eq("t1_head_pc",  32'(if_pc),        32'h0);
    check_eq("t1_head_ins", 32'(if_inst),      32'h1000);
    wait_pops(4, "t1");
    for (int i = 0; i < 4; i++) begin
      check_eq("t1_pc",   32'(q_pc[i]),   32'(i));
      check_eq("t1_inst", 32'(q_inst[i]), 32'(i + 'h1000));
    end

    // Back-pressure: buffer fills to two and fetching stops
    id_ready = 1'b0;
    repeat (10) tick();
    check_eq("t2_req",   32'(bus.imem_req), 32'd0);
    check_eq("t2_valid", 32'(if_valid),     32'd1);
    check_eq("t2_pc",    32'(if_pc),        32'h4);
    check_eq("t2_inst",  32'(if_inst),      32'h1004);
    clear_q();
    id_ready = 1'b1;
    wait_pops(4, "t2");
    for (int i = 0; i < 4; i++) begin
      check_eq("t2_seq_pc",   32'(q_pc[i]),   32'(i + 4));
      check_eq("t2_seq_inst", 32'(q_inst[i]), 32'(i + 'h1004));
    end

    // Jump in IDLE with a full buffer
    id_ready = 1'b0;
    repeat (10) tick();
    check_eq("t3_full_req", 32'(bus.imem_req), 32'd0);
    check_eq("t3_full_pc",  32'(if_pc),        32'h8);
    jump = PC_JUMP;
    tgt  = 16'h0040;
    tick();
    jump = PC_JUMP_DISABLE;
    check_eq("t3_valid", 32'(if_valid),     32'd0);
    check_eq("t3_req",   32'(bus.imem_req), 32'd0);
    check_eq("t3_plus",  32'(PC_plus),      32'h41);
    tick();
    check_eq("t3_req2",  32'(bus.imem_req),  32'd1);
    check_eq("t3_addr",  32'(bus.imem_addr), 32'h40);
    clear_q();
    id_ready = 1'b1;
    wait_pops(1, "t3");
    check_eq("t3_pop_pc",   32'(q_pc[0]),   32'h40);
    check_eq("t3_pop_inst", 32'(q_inst[0]), 32'h1040);

    // Jump in the second WAIT cycle of a 3-wait fetch
    mdly = 3;
    wait_req(1'b0, "t4a");
    wait_req(1'b1, "t4b");
    old_addr = bus.imem_addr;
    tick();
    jump = PC_JUMP;
    tgt  = 16'h0100;
    tick();
    jump = PC_JUMP_DISABLE;
    clear_q();
    check_eq("t4_valid",   32'(if_valid),      32'd0);
    check_eq("t4_req_d",   32'(bus.imem_req),  32'd1);
    check_eq("t4_addr_d",  32'(bus.imem_addr), 32'(old_addr));
    tick();
    check_eq("t4_ack",     32'(bus.imem_ack),  32'd1);
    check_eq("t4_addr_a",  32'(bus.imem_addr), 32'(old_addr));
    tick();
    check_eq("t4_req_idle", 32'(bus.imem_req), 32'd0);
    tick();
    check_eq("t4_req_new", 32'(bus.imem_req),  32'd1);
    check_eq("t4_addr_new", 32'(bus.imem_addr), 32'h100);
    wait_pops(1, "t4");
    check_eq("t4_pop_pc",   32'(q_pc[0]),   32'h100);
    check_eq("t4_pop_inst", 32'(q_inst[0]), 32'h1100);

    // Jump coincident with ack and pop
    mdly     = 0;
    id_ready = 1'b0;
    found    = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick();
      found = if_valid && bus.imem_req && bus.imem_ack;
    end
    check_eq("t5_found", 32'(found), 32'd1);
    id_ready = 1'b1;
    jump     = PC_JUMP;
    tgt      = 16'h0200;
    tick();
    jump = PC_JUMP_DISABLE;
    clear_q();
    check_eq("t5_valid", 32'(if_valid),     32'd0);
    check_eq("t5_req",   32'(bus.imem_req), 32'd0);
    tick();
    check_eq("t5_req2",  32'(bus.imem_req),  32'd1);
    check_eq("t5_addr",  32'(bus.imem_addr), 32'h200);
    wait_pops(1, "t5");
    check_eq("t5_pop_pc",   32'(q_pc[0]),   32'h200);
    check_eq("t5_pop_inst", 32'(q_inst[0]), 32'h1200);

    // Asynchronous reset mid-WAIT, restart, PC wrap
    mdly = 3;
    wait_req(1'b0, "t6a");
    wait_req(1'b1, "t6b");
    tick();
    rst_n = 1'b0;
    #1;
    check_eq("t6_req",   32'(bus.imem_req),  32'd0);
    check_eq("t6_addr",  32'(bus.imem_addr), 32'h0);
    check_eq("t6_valid", 32'(if_valid),      32'd0);
    check_eq("t6_pc",    32'(if_pc),         32'h0);
    check_eq("t6_inst",  32'(if_inst),       32'h0);
    check_eq("t6_plus",  32'(PC_plus),       32'h1);
    tick();
    check_eq("t6_req_hold", 32'(bus.imem_req), 32'd0);
    rst_n = 1'b1;
    mdly  = 0;
    tick();
    check_eq("t6_restart_req",  32'(bus.imem_req),  32'd1);
    check_eq("t6_restart_addr", 32'(bus.imem_addr), 32'h0);
    jump = PC_JUMP;
    tgt  = 16'hFFFF;
    tick();
    jump = PC_JUMP_DISABLE;
    check_eq("t6_wrap_plus", 32'(PC_plus),      32'h0);
    check_eq("t6_wrap_req0", 32'(bus.imem_req), 32'd0);
    tick();
    check_eq("t6_wrap_req",  32'(bus.imem_req),  32'd1);
    check_eq("t6_wrap_addr", 32'(bus.imem_addr), 32'hFFFF);
    tick();
    check_eq("t6_wrap_valid", 32'(if_valid), 32'd1);
    check_eq("t6_wrap_pc",    32'(if_pc),    32'hFFFF);
    check_eq("t6_wrap_inst",  32'(if_inst),  32'h0FFF);
    check_eq("t6_wrap_plus1", 32'(PC_plus),  32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pc_fetch.md
# pc_fetch

Fetch stage sitting directly around the PC jump mux: it holds the architectural fetch PC and drives PC_plus into the mux. It takes the selected PC_new back from the mux and issues word fetches to instruction memory over a req/ack handshake. Fetched {pc, instruction} pairs are buffered for the decode stage, and the buffer is flushed on a taken jump.

## Interface
- PC_WIDTH, 16, width of PC and instruction-memory address (`PC_BUS`)
- INST_WIDTH, 16, instruction word width
- RESET_PC, 0, fetch address after reset
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- PC_plus  out  PC_WIDTH  PC + 1 (word addressed), to jump mux
- PC_new  in  PC_WIDTH  next PC selected by jump mux
- pc_jump_op  in  1  `PC_JUMP` (1'b1) = taken jump this cycle; PC_new is then the target
- imem_req  out  1  fetch request, registered
- imem_addr  out  PC_WIDTH  fetch address, registered, stable while imem_req high
- imem_ack  in  1  fetch complete; imem_data valid this cycle
- imem_data  in  INST_WIDTH  fetched word
- if_valid  out  1  buffer head valid
- if_pc  out  PC_WIDTH  PC of head instruction
- if_inst  out  INST_WIDTH  head instruction
- id_ready  in  1  decode accepts head (pop = if_valid && id_ready)

## Operation
- Registers: PC, imem_addr, state, 2-entry fetch buffer.
- PC_plus = PC + 1, combinational, wraps modulo 2^PC_WIDTH.
- States: IDLE (no request outstanding), WAIT (request outstanding, data kept), DISCARD (request outstanding, data dropped). imem_req = (state != IDLE).
- IDLE, no jump, buffer count < 2 (count sampled before this cycle's pop): imem_addr <= PC, go WAIT.
- IDLE, count == 2: stay.
- IDLE, jump: PC <= PC_new, flush buffer, stay IDLE; issue from target next cycle.
- WAIT, ack, no jump: push {imem_addr, imem_data}, PC <= PC_new (equals PC_plus), go IDLE.
- WAIT, ack with jump: drop data, PC <= PC_new, flush, go IDLE.
- WAIT, no ack, jump: PC <= PC_new, flush, go DISCARD; imem_addr unchanged.
- WAIT, no ack, no jump: hold.
- DISCARD, ack: drop data, go IDLE.
- DISCARD, jump: PC <= PC_new, flush, stay.
- Only one request outstanding at any time.
- Buffer: FIFO order. Push and pop in the same cycle are both allowed. Flush has priority over push and pop, and the count goes to 0.
- Push never happens when count == 2, because issue requires count < 2.
- Reset (asynchronous, any state, including mid-request): PC = RESET_PC, imem_addr = RESET_PC, state = IDLE, imem_req = 0, count = 0, if_valid = 0, if_pc = 0, if_inst = 0. An ack arriving in IDLE is ignored.

## Timing
- First imem_req rises on the first clock edge after rst_n deasserts, with imem_addr = RESET_PC.
- Zero-wait memory (ack in the first WAIT cycle) sustains one fetch per 2 cycles.
- Ack-to-if_valid latency: 1 cycle (registered push).
- Jump-to-new-request: 1 cycle from IDLE or WAIT+ack. From WAIT/DISCARD without ack, 1 cycle after the stale ack.
- if_valid drops on the edge after a jump.

## Structure
- Shared package/`define.v`: `PC_BUS`, `PC_JUMP`/`PC_JUMP_DISABLE`, state encodings (FETCH_IDLE, FETCH_WAIT, FETCH_DISCARD), RESET_PC.
- Sub-module fetch_buf: 2-entry synchronous FIFO with push, pop, flush, count, and head outputs, parameterised on entry width.

## Test plan
- Reset release, zero-wait memory, id_ready = 1 → imem_addr 0,1,2,3 on successive requests; if_pc/if_inst match in order; PC_plus = PC + 1.
- id_ready = 0 for 10 cycles → exactly 2 entries buffered, imem_req stays low, no address skipped after id_ready returns.
- Jump to 0x0040 in IDLE with 2 entries buffered → if_valid = 0 next cycle, next imem_addr = 0x0040.
- Ack delayed 3 cycles, jump to 0x0100 in the second WAIT cycle → imem_addr stays old until ack, that data is never pushed, then a request to 0x0100 follows.
- Jump coincident with ack and pop → data dropped, buffer empty, next request = target.
- rst_n pulsed low mid-WAIT → outputs at reset values immediately, restart fetching at RESET_PC; PC 0xFFFF wraps to PC_plus 0x0000.
